// File: rtl/stage_if.sv
// stage_if - instruction-fetch stage of the 5-stage RISC-V pipeline.
//
// Owns the fetch PC and issues word requests to instruction memory
// (request/grant, in-order responses). Returned words pass through a small
// FIFO and reach decode through a registered {pc, inst} output. Decode can
// stall, and execute can redirect the fetch stream.
//
// Ports:
//   clk, rst     rising-edge clock, synchronous active-high reset
//   stall        decode cannot accept; id_* outputs hold
//   br_taken     redirect from execute (overrides stall)
//   br_target    redirect PC, low two bits ignored
//   mem_req      fetch request valid
//   mem_addr     fetch address (word aligned)
//   mem_gnt      memory accepts the request this cycle
//   mem_rvalid   response word valid (responses arrive in request order)
//   mem_rdata    response instruction word
//   id_valid     id_pc/id_inst hold a real instruction
//   id_pc        PC of the presented instruction
//   id_inst      presented instruction, NOP when id_valid=0
module stage_if #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst
);

  localparam int unsigned AW = $clog2(QUEUE_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(QUEUE_DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   q_pc   [QUEUE_DEPTH];
  logic [31:0]   q_inst [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] q_count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] out_after_resp;
  logic [CW:0]   in_use;

  logic q_empty;
  logic fire;
  logic drop_now;
  logic accept;
  logic push;
  logic pop;

  // Issue credit counts both buffered words and words still in flight, so a
  // response pushed while decode is stalled always finds a free slot.
  assign in_use   = {1'b0, outstanding} + {1'b0, q_count};
  assign mem_req  = !rst && !br_taken && (in_use < DEPTH_W);
  assign mem_addr = fetch_pc;
  assign fire     = mem_req && mem_gnt;

  assign q_empty        = (q_count == '0);
  assign drop_now       = mem_rvalid && (drop_cnt != '0);
  assign accept         = !rst && !br_taken && mem_rvalid && (drop_cnt == '0);
  assign out_after_resp = outstanding - CW'(mem_rvalid);

  // A word goes into the FIFO unless it bypasses straight to the output
  // register (decode free and nothing older buffered).
  assign pop  = !rst && !br_taken && !stall && !q_empty;
  assign push = accept && (stall || !q_empty);

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]   <= resp_pc;
      q_inst[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_count     <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_inst     <= NOP;
    end else if (br_taken) begin
      fetch_pc    <= {br_target[31:2], 2'b00};
      resp_pc     <= {br_target[31:2], 2'b00};
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      q_count     <= '0;
      // Every word still in flight after this cycle belongs to the old path.
      outstanding <= out_after_resp;
      drop_cnt    <= out_after_resp;
      id_valid    <= 1'b0;
      id_inst     <= NOP;
    end else begin
      if (fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
      outstanding <= outstanding + CW'(fire) - CW'(mem_rvalid);
      if (drop_now) begin
        drop_cnt <= drop_cnt - CW'(1);
      end
      if (accept) begin
        resp_pc <= resp_pc + 32'd4;
      end
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      q_count <= q_count + CW'(push) - CW'(pop);

      if (!stall) begin
        if (!q_empty) begin
          id_valid <= 1'b1;
          id_pc    <= q_pc[rd_ptr];
          id_inst  <= q_inst[rd_ptr];
        end else if (accept) begin
          id_valid <= 1'b1;
          id_pc    <= resp_pc;
          id_inst  <= mem_rdata;
        end else begin
          id_valid <= 1'b0;
          id_inst  <= NOP;
        end
      end
    end
  end

endmodule
